// File: rtl/imply_pkg.sv
// rtl/imply_pkg.sv - shared types and defaults for the implication stack
package imply_pkg;

`include "sysdefs.svh"

    typedef struct packed {
        logic [MAX_VARS_BITS-1:0] var_idx;
        logic                     val;
    } imply_entry_t;

    localparam int IMPLY_STACK_DEPTH = 16;

endpackage

// File: rtl/imply_stack_mem.sv
// rtl/imply_stack_mem.sv - unreset entry array, one write port, one combinational read port
module imply_stack_mem
    import imply_pkg::*;
#(
    parameter int DEPTH = IMPLY_STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  imply_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output imply_entry_t rdata
);

    imply_entry_t mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sysdefs.svh
// rtl/sysdefs.svh - solver-wide sizing constants
`ifndef SYSDEFS_SVH
`define SYSDEFS_SVH

localparam int MAX_VARS_BITS = 8;

`endif

// File: rtl/imply_stack.sv
// rtl/imply_stack.sv - LIFO of implied (variable, value) pairs; IMPLY_STACK_HWM_EN adds a high-water mark port
module imply_stack
    import imply_pkg::*;
#(
    parameter int DEPTH    = IMPLY_STACK_DEPTH,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_en,
    input  logic [MAX_VARS_BITS-1:0] push_var_idx,
    input  logic                     push_val,
    input  logic                     pop_en,
    input  logic                     flush,
    output logic [MAX_VARS_BITS-1:0] top_var_idx,
    output logic                     top_val,
    output logic                     top_valid,
    output logic                     empty,
    output logic                     full,
    output logic [CNT_BITS-1:0]      count,
`ifdef IMPLY_STACK_HWM_EN
    output logic                     overflow,
    output logic [CNT_BITS-1:0]      hwm
`else
    output logic                     overflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [CNT_BITS-1:0] count_q, count_d, count_m1;
    logic                overflow_q, overflow_d;
    logic                is_empty, is_full;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr, mem_raddr;
    imply_entry_t        wr_entry, rd_entry;

    assign count_m1  = count_q - CNT_BITS'(1);
    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == CNT_BITS'(DEPTH));
    assign mem_raddr = count_m1[AW-1:0];
    assign wr_entry  = '{var_idx: push_var_idx, val: push_val};

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = count_q[AW-1:0];
        if (flush) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (push_en && pop_en) begin
            // Replacing the top keeps depth constant, so a full stack never overflows here
            mem_we = 1'b1;
            if (is_empty) begin
                mem_waddr = '0;
                count_d   = CNT_BITS'(1);
            end else begin
                mem_waddr = mem_raddr;
            end
        end else if (push_en) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                mem_we  = 1'b1;
                count_d = count_q + CNT_BITS'(1);
            end
        end else if (pop_en) begin
            if (!is_empty) begin
                count_d = count_m1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef IMPLY_STACK_HWM_EN
    logic [CNT_BITS-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    imply_stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (wr_entry),
        .raddr (mem_raddr),
        .rdata (rd_entry)
    );

    assign top_var_idx = is_empty ? '0 : rd_entry.var_idx;
    assign top_val     = is_empty ? 1'b0 : rd_entry.val;
    assign top_valid   = !is_empty;
    assign empty       = is_empty;
    assign full        = is_full;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_imply_stack.sv
// tb/tb_imply_stack.sv - randomized and directed self-checking bench for imply_stack
module tb_imply_stack;
    import imply_pkg::*;

    localparam int DEPTH    = 16;
    localparam int CNT_BITS = 5;
    localparam int MVB      = MAX_VARS_BITS;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                push_en = 1'b0;
    logic [MVB-1:0]      push_var_idx = '0;
    logic                push_val = 1'b0;
    logic                pop_en = 1'b0;
    logic                flush = 1'b0;
    logic [MVB-1:0]      top_var_idx;
    logic                top_val;
    logic                top_valid;
    logic                empty;
    logic                full;
    logic [CNT_BITS-1:0] count;
    logic                overflow;
`ifdef IMPLY_STACK_HWM_EN
    logic [CNT_BITS-1:0] hwm;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [MVB-1:0] idx;
        logic           val;
    } m_ent_t;

    m_ent_t mq[$];
    bit     m_ovf;
    int     m_hwm;

    imply_stack #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .push_en      (push_en),
        .push_var_idx (push_var_idx),
        .push_val     (push_val),
        .pop_en       (pop_en),
        .flush        (flush),
        .top_var_idx  (top_var_idx),
        .top_val      (top_val),
        .top_valid    (top_valid),
        .empty        (empty),
        .full         (full),
        .count        (count),
`ifdef IMPLY_STACK_HWM_EN
        .overflow     (overflow),
        .hwm          (hwm)
`else
        .overflow     (overflow)
`endif
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_hwm = 0;
    endtask

    task automatic do_cycle(input bit pu, input int idx, input bit v, input bit po, input bit fl);
        m_ent_t e;
        @(negedge clock);
        push_en      = pu;
        push_var_idx = MVB'(idx);
        push_val     = v;
        pop_en       = po;
        flush        = fl;
        @(posedge clock);
        e.idx = MVB'(idx);
        e.val = v;
        if (fl) begin
            model_clear();
        end else if (pu && po) begin
            if (mq.size() > 0) mq[mq.size()-1] = e;
            else mq.push_back(e);
        end else if (pu) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end
        if (mq.size() > m_hwm) m_hwm = mq.size();
        #1;
        push_en = 1'b0;
        pop_en  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || top_valid !== 1'b0 ||
            overflow !== 1'b0 || top_var_idx !== '0 || top_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d emp=%0b full=%0b tv=%0b ovf=%0b top=(%0d,%0b) exp cnt=0 emp=1 full=0 tv=0 ovf=0 top=(0,0)",
                     count, empty, full, top_valid, overflow, top_var_idx, top_val);
        end
        @(negedge clock);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_push_pop();
        do_cycle(1, 5, 1, 0, 0);
        do_cycle(1, 9, 0, 0, 0);
        checks++;
        if (top_var_idx !== 8'd9 || top_val !== 1'b0 || count !== 5'd2 || top_valid !== 1'b1) begin
            errors++;
            $display("FAIL push_two got top=(%0d,%0b) cnt=%0d tv=%0b exp top=(9,0) cnt=2 tv=1",
                     top_var_idx, top_val, count, top_valid);
        end
        do_cycle(0, 0, 0, 1, 0);
        checks++;
        if (top_var_idx !== 8'd5 || top_val !== 1'b1 || count !== 5'd1) begin
            errors++;
            $display("FAIL pop_one got top=(%0d,%0b) cnt=%0d exp top=(5,1) cnt=1",
                     top_var_idx, top_val, count);
        end
        do_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_full_overflow_flush();
        for (int i = 0; i < DEPTH; i++) do_cycle(1, i, i[0], 0, 0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0 || top_var_idx !== 8'd15) begin
            errors++;
            $display("FAIL fill got full=%0b cnt=%0d ovf=%0b top=%0d exp full=1 cnt=16 ovf=0 top=15",
                     full, count, overflow, top_var_idx);
        end
        do_cycle(1, 15, 0, 1, 0);
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16 || top_val !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got ovf=%0b cnt=%0d val=%0b exp ovf=0 cnt=16 val=0",
                     overflow, count, top_val);
        end
        do_cycle(1, 20, 1, 0, 0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || top_var_idx !== 8'd15) begin
            errors++;
            $display("FAIL overflow got full=%0b cnt=%0d ovf=%0b top=%0d exp full=1 cnt=16 ovf=1 top=15",
                     full, count, overflow, top_var_idx);
        end
        do_cycle(0, 0, 0, 1, 0);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd15 || top_var_idx !== 8'd14) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%0b cnt=%0d top=%0d exp ovf=1 cnt=15 top=14",
                     overflow, count, top_var_idx);
        end
        do_cycle(1, 3, 1, 1, 1);
        checks++;
        if (count !== '0 || overflow !== 1'b0 || empty !== 1'b1 || top_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush got cnt=%0d ovf=%0b emp=%0b tv=%0b exp cnt=0 ovf=0 emp=1 tv=0",
                     count, overflow, empty, top_valid);
        end
    endtask

    task automatic test_replace_top();
        do_cycle(1, 2, 0, 0, 0);
        do_cycle(1, 4, 0, 0, 0);
        do_cycle(1, 7, 1, 0, 0);
        do_cycle(1, 12, 0, 1, 0);
        checks++;
        if (count !== 5'd3 || top_var_idx !== 8'd12 || top_val !== 1'b0) begin
            errors++;
            $display("FAIL replace_top got cnt=%0d top=(%0d,%0b) exp cnt=3 top=(12,0)",
                     count, top_var_idx, top_val);
        end
        do_cycle(0, 0, 0, 1, 0);
        checks++;
        if (count !== 5'd2 || top_var_idx !== 8'd4) begin
            errors++;
            $display("FAIL below_replaced got cnt=%0d top=%0d exp cnt=2 top=4", count, top_var_idx);
        end
        do_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_empty_edges();
        do_cycle(0, 0, 0, 1, 0);
        checks++;
        if (count !== '0 || overflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_pop got cnt=%0d ovf=%0b emp=%0b exp cnt=0 ovf=0 emp=1",
                     count, overflow, empty);
        end
        do_cycle(1, 77, 1, 1, 0);
        checks++;
        if (count !== 5'd1 || top_var_idx !== 8'd77 || top_val !== 1'b1 || top_valid !== 1'b1) begin
            errors++;
            $display("FAIL empty_push_pop got cnt=%0d top=(%0d,%0b) tv=%0b exp cnt=1 top=(77,1) tv=1",
                     count, top_var_idx, top_val, top_valid);
        end
        do_cycle(0, 0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 40 + i, 1, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== '0 || top_valid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d tv=%0b emp=%0b exp cnt=0 tv=0 emp=1",
                     count, top_valid, empty);
        end
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset        = 1'b1;
        push_en      = 1'b1;
        push_var_idx = 8'd33;
        push_val     = 1'b1;
        @(posedge clock);
        mq.push_back('{idx: 8'd33, val: 1'b1});
        m_hwm = 1;
        #1;
        push_en = 1'b0;
        checks++;
        if (count !== 5'd1 || top_var_idx !== 8'd33 || top_val !== 1'b1) begin
            errors++;
            $display("FAIL first_push_after_reset got cnt=%0d top=(%0d,%0b) exp cnt=1 top=(33,1)",
                     count, top_var_idx, top_val);
        end
        do_cycle(0, 0, 0, 0, 1);
    endtask

`ifdef IMPLY_STACK_HWM_EN
    task automatic test_hwm();
        for (int i = 0; i < 6; i++) do_cycle(1, i, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 1, 0);
        do_cycle(1, 50, 1, 0, 0);
        checks++;
        if (hwm !== 5'd6 || count !== 5'd3) begin
            errors++;
            $display("FAIL hwm_peak got hwm=%0d cnt=%0d exp hwm=6 cnt=3", hwm, count);
        end
        do_cycle(0, 0, 0, 0, 1);
        checks++;
        if (hwm !== '0) begin
            errors++;
            $display("FAIL hwm_flush got hwm=%0d exp 0", hwm);
        end
    endtask
`endif

    task automatic test_random();
        int exp_idx;
        int exp_val;
        int push_pct;
        bit pu, po, fl;
        for (int cyc = 0; cyc < 600; cyc++) begin
            push_pct = ((cyc / 100) % 2 == 0) ? 75 : 30;
            pu = ($urandom_range(0, 99) < push_pct);
            po = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 59) == 0);
            do_cycle(pu, int'($urandom_range(0, (1 << MVB) - 1)), 1'($urandom), po, fl);
            exp_idx = (mq.size() > 0) ? int'(mq[mq.size()-1].idx) : 0;
            exp_val = (mq.size() > 0) ? int'(mq[mq.size()-1].val) : 0;
            checks++;
            if (int'(count) != mq.size() || top_valid !== (mq.size() > 0) ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                errors++;
                $display("FAIL rnd_count cyc=%0d got cnt=%0d tv=%0b emp=%0b full=%0b exp cnt=%0d",
                         cyc, count, top_valid, empty, full, mq.size());
            end
            checks++;
            if (int'(top_var_idx) != exp_idx || int'(top_val) != exp_val) begin
                errors++;
                $display("FAIL rnd_top cyc=%0d got (%0d,%0b) exp (%0d,%0d)",
                         cyc, top_var_idx, top_val, exp_idx, exp_val);
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_overflow cyc=%0d got %0b exp %0b", cyc, overflow, m_ovf);
            end
`ifdef IMPLY_STACK_HWM_EN
            checks++;
            if (int'(hwm) != m_hwm) begin
                errors++;
                $display("FAIL rnd_hwm cyc=%0d got %0d exp %0d", cyc, hwm, m_hwm);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full_overflow_flush();
        test_replace_top();
        test_empty_edges();
        test_async_reset();
`ifdef IMPLY_STACK_HWM_EN
        test_hwm();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
